ex_mem_req_unit: RTL and testbench

EX_MEM_REQ_UNIT -- requirements
Module: ex_mem_req_unit

---
 rtl/mem_pkg.sv | 12 +
 rtl/req_info_fifo.sv | 39 +++
 rtl/ex_mem_req_unit.sv | 80 ++++++++
 tb/tb_ex_mem_req_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings and the per-request info record shared by the memory request path
package mem_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    typedef struct packed {
        logic       load;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } req_info_t;
endpackage

// File: rtl/req_info_fifo.sv
// req_info_fifo: in-order record of issued requests; pop on full may coincide with push
module req_info_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  req_info_t                din,
    output req_info_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    req_info_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];
    always_ff @(posedge clk) if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ex_mem_req_unit.sv
// ex_mem_req_unit: issues EX-stage loads/stores to data SRAM, tracks in-flight requests and shapes responses.
// Define EX_MEM_ALE_EN to flag misaligned half/word accesses (ale) instead of issuing them.
module ex_mem_req_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_load,
    input  logic                         in_store,
    input  logic [1:0]                   in_size,
    input  logic                         in_unsigned,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [31:0]                  in_wdata,
    input  logic                         flush,
    output logic                         ale,
    output logic                         req,
    output logic                         wr,
    output logic [1:0]                   size,
    output logic [3:0]                   wstrb,
    output logic [ADDR_W-1:0]            addr,
    output logic [31:0]                  wdata,
    input  logic                         addr_ok,
    input  logic                         data_ok,
    input  logic [31:0]                  rdata,
    output logic                         resp_valid,
    output logic [31:0]                  resp_data,
    output logic [$clog2(MAX_OUTST):0]   outst
);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    logic mem_op, push, pop, full, empty;
    logic [CW-1:0] total, total_next, disc;
    logic [31:0] sh;
    req_info_t head;
    assign mem_op = in_load | in_store;
`ifdef EX_MEM_ALE_EN
    assign ale = in_valid & mem_op & ((in_size == SZ_H & in_addr[0]) | (in_size == SZ_W & |in_addr[1:0]));
`else
    assign ale = 1'b0;
`endif
    assign req      = resetn & in_valid & mem_op & ~ale & ~flush & ~full;
    assign in_ready = ~mem_op | ale | (req & addr_ok);
    assign wr       = in_store;
    assign size     = in_size;
    assign addr     = in_addr;
    assign wstrb    = ~in_store ? 4'b0000 :
                      in_size == SZ_B ? 4'b0001 << in_addr[1:0] :
                      in_size == SZ_H ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata    = in_size == SZ_B ? {4{in_wdata[7:0]}} :
                      in_size == SZ_H ? {2{in_wdata[15:0]}} : in_wdata;
    assign push     = req & addr_ok;
    assign pop      = data_ok & ~empty;
    req_info_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    ('{load: in_load, size: in_size, uns: in_unsigned, off: in_addr[1:0]}),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (total)
    );
    assign total_next = total + CW'(push) - CW'(pop);
    // Everything still in flight when flush hits belongs to cancelled ops.
    always_ff @(posedge clk) begin
        if (!resetn) disc <= '0;
        else disc <= flush ? total_next : (pop && disc != '0) ? disc - 1'b1 : disc;
    end
    assign outst      = total - disc;
    assign resp_valid = resetn & pop & (disc == '0);
    assign sh         = rdata >> {head.off, 3'b000};
    assign resp_data  = ~head.load ? 32'd0 :
                        head.size == SZ_B ? {{24{~head.uns & sh[7]}}, sh[7:0]} :
                        head.size == SZ_H ? {{16{~head.uns & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: tb/tb_ex_mem_req_unit.sv
// tb_ex_mem_req_unit: directed stimulus checked against a queue-based model plus literal expectations
module tb_ex_mem_req_unit;
    logic clk = 0, resetn = 0;
    logic in_valid = 0, in_ready, in_load = 0, in_store = 0, in_unsigned = 0, flush = 0, ale;
    logic [1:0] in_size = 0, size;
    logic [31:0] in_addr = 0, in_wdata = 0, addr, wdata, rdata = 0, resp_data;
    logic req, wr, addr_ok = 0, data_ok = 0, resp_valid;
    logic [3:0] wstrb;
    logic [2:0] outst;
    int checks = 0, passes = 0;

    ex_mem_req_unit #(.ADDR_W(32), .MAX_OUTST(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
        .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .flush(flush), .ale(ale), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .resp_valid(resp_valid), .resp_data(resp_data), .outst(outst)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       ld;
        bit [1:0] sz;
        bit       uns;
        bit [1:0] off;
    } ent_t;
    ent_t q[$];
    int disc_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_mem();
        return in_load | in_store;
    endfunction

    function automatic bit m_ale();
        bit a = 0;
`ifdef EX_MEM_ALE_EN
        a = in_valid && m_mem() && ((in_size == 1 && in_addr[0]) || (in_size == 2 && in_addr[1:0] != 0));
`endif
        return a;
    endfunction

    function automatic bit m_req();
        return resetn && in_valid && m_mem() && !m_ale() && !flush && q.size() < 4;
    endfunction

    function automatic logic [31:0] m_ext(input ent_t e, input logic [31:0] rd);
        logic [31:0] s, v;
        s = rd >> (8 * e.off);
        if (!e.ld) return 0;
        if (e.sz == 0) begin
            v = s & 32'hFF;
            if (!e.uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (e.sz == 1) begin
            v = s & 32'hFFFF;
            if (!e.uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else v = s;
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb();
        if (!in_store) return 0;
        if (in_size == 0) return 4'(1 << in_addr[1:0]);
        if (in_size == 1) return 4'(3 << (in_addr[1:0] & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata();
        if (in_size == 0) return {4{in_wdata[7:0]}};
        if (in_size == 1) return {2{in_wdata[15:0]}};
        return in_wdata;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            chk("req", req, m_req());
            chk("ale", ale, m_ale());
            chk("in_ready", in_ready, !m_mem() || m_ale() || (m_req() && addr_ok));
            chk("outst", outst, q.size() - disc_m);
            chk("resp_valid", resp_valid, resetn && data_ok && q.size() > 0 && disc_m == 0);
            if (resetn && data_ok && q.size() > 0 && disc_m == 0) chk("resp_data", resp_data, m_ext(q[0], rdata));
            if (in_valid && m_mem()) begin
                chk("wr", wr, in_store);
                chk("size", size, in_size);
                chk("addr", addr, in_addr);
                chk("wstrb", wstrb, m_wstrb());
                chk("wdata", wdata, m_wdata());
            end
            @(posedge clk);
            if (!resetn) begin
                q.delete();
                disc_m = 0;
            end else begin
                bit p, d;
                p = m_req() && addr_ok;
                d = data_ok && q.size() > 0;
                if (d) begin
                    void'(q.pop_front());
                    if (disc_m > 0) disc_m--;
                end
                if (p) q.push_back('{ld: in_load, sz: in_size, uns: in_unsigned, off: in_addr[1:0]});
                if (flush) disc_m = q.size();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, ld, st, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd);
        in_valid = v; in_load = ld; in_store = st; in_size = sz; in_unsigned = un;
        in_addr = a; in_wdata = wd;
    endtask

    task automatic bus(input logic aok, dok, input logic [31:0] rd);
        addr_ok = aok; data_ok = dok; rdata = rd;
    endtask

    initial begin
        op(1, 1, 0, 2, 0, 32'h1000, 0); bus(1, 1, 32'h5); flush = 1;
        cyc(); cyc();
        #1 chk("rst_req", req, 0); chk("rst_outst", outst, 0); chk("rst_resp", resp_valid, 0);
        resetn = 1; flush = 0; op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'h77);
        #1 chk("post_rst_dok", resp_valid, 0);
        cyc(); bus(0, 0, 0);
        #1 chk("post_rst_outst", outst, 0);
        // single word load
        op(1, 1, 0, 2, 0, 32'h1000, 0); bus(1, 0, 0);
        #1 chk("ldw_req", req, 1); chk("ldw_wstrb", wstrb, 0); chk("ldw_ready", in_ready, 1); chk("ldw_outst0", outst, 0);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'hDEADBEEF);
        #1 chk("ldw_outst1", outst, 1); chk("ldw_rv", resp_valid, 1); chk("ldw_rd", resp_data, 32'hDEADBEEF);
        cyc(); bus(0, 0, 0);
        #1 chk("ldw_outst2", outst, 0);
        // byte store, then byte loads signed/unsigned, then signed half
        op(1, 0, 1, 0, 0, 32'h1003, 32'h12); bus(1, 0, 0);
        #1 chk("stb_wstrb", wstrb, 4'b1000); chk("stb_wdata", wdata, 32'h12121212); chk("stb_wr", wr, 1);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'hFFFFFFFF);
        #1 chk("stb_rv", resp_valid, 1); chk("stb_rd", resp_data, 0);
        cyc(); op(1, 1, 0, 0, 0, 32'h1002, 0); bus(1, 0, 0);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'h00800000);
        #1 chk("ldb_s", resp_data, 32'hFFFFFF80);
        cyc(); op(1, 1, 0, 0, 1, 32'h1002, 0); bus(1, 0, 0);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'h00800000);
        #1 chk("ldb_u", resp_data, 32'h00000080);
        cyc(); op(1, 1, 0, 1, 0, 32'h1002, 0); bus(1, 0, 0);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'h80010000);
        #1 chk("ldh_s", resp_data, 32'hFFFF8001);
        cyc(); bus(0, 0, 0);
        // misaligned half
        op(1, 1, 0, 1, 0, 32'h1001, 0);
`ifdef EX_MEM_ALE_EN
        #1 chk("mis_ale", ale, 1); chk("mis_req", req, 0); chk("mis_ready", in_ready, 1);
`else
        #1 chk("mis_ale", ale, 0); chk("mis_req", req, 1); chk("mis_ready", in_ready, 0);
`endif
        cyc(); op(0, 0, 0, 0, 0, 0, 0);
        // fill to MAX_OUTST, fifth held until a response drains one
        for (int i = 0; i < 4; i++) begin
            op(1, 1, 0, 2, 0, 32'h2000 + 4 * i, 0); bus(1, 0, 0); cyc();
        end
        op(1, 1, 0, 2, 0, 32'h2010, 0);
        #1 chk("full_req", req, 0); chk("full_ready", in_ready, 0); chk("full_outst", outst, 4);
        cyc(); bus(1, 1, 32'hA0);
        #1 chk("full_req2", req, 0); chk("full_rv", resp_valid, 1);
        cyc(); bus(1, 0, 0);
        #1 chk("fifth_req", req, 1); chk("fifth_outst", outst, 3);
        cyc(); op(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus(0, 1, 32'hB0 + i); cyc();
        end
        bus(0, 0, 0);
        #1 chk("drain_outst", outst, 0);
        // flush with three in flight and a coincident fourth offer
        for (int i = 0; i < 3; i++) begin
            op(1, 1, 0, 2, 0, 32'h3000 + 4 * i, 0); bus(1, 0, 0); cyc();
        end
        op(1, 1, 0, 2, 0, 32'h300C, 0); flush = 1;
        #1 chk("fl_req", req, 0);
        cyc(); flush = 0; op(0, 0, 0, 0, 0, 0, 0); bus(0, 0, 0);
        #1 chk("fl_outst", outst, 0);
        for (int i = 0; i < 4; i++) begin
            bus(0, 1, 32'hC0 + i);
            #1 chk("fl_disc_rv", resp_valid, 0);
            cyc();
        end
        op(1, 1, 0, 2, 0, 32'h3100, 0); bus(1, 0, 0);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 1, 32'h12345678);
        #1 chk("fl_fresh_rv", resp_valid, 1); chk("fl_fresh_rd", resp_data, 32'h12345678);
        cyc();
        // concurrent addr_ok/data_ok keeps count and ordering
        op(1, 1, 0, 2, 0, 32'h4000, 0); bus(1, 0, 0); cyc();
        op(1, 1, 0, 0, 1, 32'h4001, 0); cyc();
        op(1, 1, 0, 1, 0, 32'h4002, 0); bus(1, 1, 32'h11111111);
        #1 chk("cc_rd0", resp_data, 32'h11111111);
        cyc(); op(0, 0, 0, 0, 0, 0, 0); bus(0, 0, 0);
        #1 chk("cc_outst", outst, 2);
        bus(0, 1, 32'h0000AB00);
        #1 chk("cc_rd1", resp_data, 32'h000000AB);
        cyc(); bus(0, 1, 32'hF00F0000);
        #1 chk("cc_rd2", resp_data, 32'hFFFFF00F);
        cyc(); bus(0, 0, 0);
        #1 chk("cc_outst0", outst, 0);
        // reset while requests are in flight overrides data_ok and flush
        op(1, 1, 0, 2, 0, 32'h5000, 0); bus(1, 0, 0); cyc(); cyc();
        op(0, 0, 0, 0, 0, 0, 0); resetn = 0; flush = 1; bus(0, 1, 32'h99);
        #1 chk("mid_rst_rv", resp_valid, 0);
        cyc(); resetn = 1; flush = 0; bus(0, 0, 0);
        #1 chk("mid_rst_outst", outst, 0);
        bus(0, 1, 32'h99);
        #1 chk("mid_rst_dok", resp_valid, 0);
        cyc(); bus(0, 0, 0);
        cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
